axi_lite_manager_bridge: RTL



---
 rtl/axi_lite_pkg.sv | 21 ++
 rtl/axi_lite_manager_bridge.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI5-Lite definitions for the manager bridge: response codes, ID width
// and the bridge state type.
package axi_lite_pkg;

    localparam int unsigned IdW = 1;

    localparam logic [2:0] RespOkay   = 3'b000;
    localparam logic [2:0] RespSlverr = 3'b010;
    localparam logic [2:0] RespDecerr = 3'b011;

    typedef enum logic [2:0] {
        StIdle,
        StWrIssue,
        StWrResp,
        StRdIssue,
        StRdResp,
        StRsp,
        StDrain
    } state_e;

endpackage

// File: rtl/axi_lite_manager_bridge.sv
// Single-outstanding AXI5-Lite manager bridge driven by a valid/ready user port.
// Define AXI_MGR_TIMEOUT_EN to add the response watchdog and the DRAIN state.
module axi_lite_manager_bridge
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [2:0]          rsp_resp,

    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic [IdW-1:0]      AWID,

    output logic                WVALID,
    input  logic                WREADY,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,

    input  logic                BVALID,
    output logic                BREADY,
    input  logic [2:0]          BRESP,
    input  logic [IdW-1:0]      BID,

    output logic                ARVALID,
    input  logic                ARREADY,
    output logic [ADDR_W-1:0]   ARADDR,
    output logic [IdW-1:0]      ARID,

    input  logic                RVALID,
    output logic                RREADY,
    input  logic [DATA_W-1:0]   RDATA,
    input  logic [2:0]          RRESP,
    input  logic [IdW-1:0]      RID
);

    if (TIMEOUT_CYCLES < 2 || (DATA_W % 8) != 0) begin : g_bad_param
        $error("TIMEOUT_CYCLES must be >= 2 and DATA_W a multiple of 8");
    end

    state_e              state_q, state_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [2:0]          rsp_resp_q, rsp_resp_d;
    logic                awvalid_q, awvalid_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [IdW-1:0]      awid_q, awid_d;
    logic                wvalid_q, wvalid_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic                bready_q, bready_d;
    logic                arvalid_q, arvalid_d;
    logic [ADDR_W-1:0]   araddr_q, araddr_d;
    logic [IdW-1:0]      arid_q, arid_d;
    logic                rready_q, rready_d;
    logic [IdW-1:0]      txn_id_q, txn_id_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;

`ifdef AXI_MGR_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pend_q, pend_d;   // an AXI response is still owed to us
    logic            write_q, write_d;
`endif

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        awvalid_d   = awvalid_q;
        awaddr_d    = awaddr_q;
        awid_d      = awid_q;
        wvalid_d    = wvalid_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        araddr_d    = araddr_q;
        arid_d      = arid_q;
        rready_d    = rready_q;
        txn_id_d    = txn_id_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
`ifdef AXI_MGR_TIMEOUT_EN
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        write_d     = write_q;
`endif

        unique case (state_q)
            StIdle: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    if (req_write) begin
                        awvalid_d = 1'b1;
                        awaddr_d  = req_addr;
                        awid_d    = txn_id_q;
                        wvalid_d  = 1'b1;
                        wdata_d   = req_wdata;
                        wstrb_d   = req_wstrb;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = StWrIssue;
                    end else begin
                        arvalid_d = 1'b1;
                        araddr_d  = req_addr;
                        arid_d    = txn_id_q;
                        state_d   = StRdIssue;
                    end
                end
            end
            StWrIssue: begin
                // AW and W complete independently, in any order or together.
                if (awvalid_q && AWREADY) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && WREADY) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    bready_d = 1'b1;
                    state_d  = StWrResp;
                end
            end
            StWrResp: begin
                if (BVALID && bready_q) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = (BID == txn_id_q) ? BRESP : RespDecerr;
                    state_d     = StRsp;
                end
            end
            StRdIssue: begin
                if (arvalid_q && ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = StRdResp;
                end
            end
            StRdResp: begin
                if (RVALID && rready_q) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = RDATA;
                    rsp_resp_d  = (RID == txn_id_q) ? RRESP : RespDecerr;
                    state_d     = StRsp;
                end
            end
            StRsp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    txn_id_d    = ~txn_id_q;
                    req_ready_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            StDrain: state_d = StIdle;
            default: state_d = StIdle;
        endcase

`ifdef AXI_MGR_TIMEOUT_EN
        if (state_q == StIdle && req_valid && req_ready_q) begin
            pend_d  = 1'b1;
            write_d = req_write;
        end
        if ((state_q == StWrResp && BVALID && bready_q) ||
            (state_q == StRdResp && RVALID && rready_q)) begin
            pend_d = 1'b0;
        end

        if ((state_q inside {StWrIssue, StWrResp, StRdIssue, StRdResp}) &&
            state_d == state_q && cnt_q >= CntW'(TIMEOUT_CYCLES - 1)) begin
            rsp_valid_d = 1'b1;
            rsp_resp_d  = RespSlverr;
            rsp_rdata_d = '0;
            state_d     = StRsp;
        end

        // After a timeout, still honour the AXI handshakes already promised and
        // swallow the late response.
        if (state_q == StRsp || state_q == StDrain) begin
            if (awvalid_q && AWREADY) awvalid_d = 1'b0;
            if (wvalid_q && WREADY) wvalid_d = 1'b0;
            if (arvalid_q && ARREADY) begin
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
            end
            if (write_q && pend_q && !awvalid_d && !wvalid_d && !bready_q) bready_d = 1'b1;
            if (bready_q && BVALID) begin
                bready_d = 1'b0;
                pend_d   = 1'b0;
            end
            if (rready_q && RVALID) begin
                rready_d = 1'b0;
                pend_d   = 1'b0;
            end
        end

        if (state_q == StRsp && state_d == StIdle && pend_d) begin
            state_d     = StDrain;
            req_ready_d = 1'b0;
        end
        if (state_q == StDrain) begin
            state_d = pend_d ? StDrain : StIdle;
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q inside {StWrIssue, StWrResp, StRdIssue, StRdResp}) begin
            cnt_d = cnt_q + 1'b1;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RespOkay;
            awvalid_q   <= 1'b0;
            awaddr_q    <= '0;
            awid_q      <= '0;
            wvalid_q    <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            araddr_q    <= '0;
            arid_q      <= '0;
            rready_q    <= 1'b0;
            txn_id_q    <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
`ifdef AXI_MGR_TIMEOUT_EN
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            write_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            awvalid_q   <= awvalid_d;
            awaddr_q    <= awaddr_d;
            awid_q      <= awid_d;
            wvalid_q    <= wvalid_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            araddr_q    <= araddr_d;
            arid_q      <= arid_d;
            rready_q    <= rready_d;
            txn_id_q    <= txn_id_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
`ifdef AXI_MGR_TIMEOUT_EN
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            write_q     <= write_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign AWVALID   = awvalid_q;
    assign AWADDR    = awaddr_q;
    assign AWID      = awid_q;
    assign WVALID    = wvalid_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = wstrb_q;
    assign BREADY    = bready_q;
    assign ARVALID   = arvalid_q;
    assign ARADDR    = araddr_q;
    assign ARID      = arid_q;
    assign RREADY    = rready_q;

endmodule
